// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared fetch-stage states, next-PC selects and opcode constants.
package fetch_sequencer_pkg;
    typedef enum logic [1:0] {FETCH = 2'b00, WAIT = 2'b01, EXEC = 2'b10, HALT = 2'b11} state_t;
    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
endpackage

// File: rtl/fetch_sequencer_pc_next_mux.sv
// pc_next_mux: next-PC select with word-alignment check; reserved select falls back to pc+4.
module pc_next_mux
    import fetch_sequencer_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [1:0]  i_pc_src,
    input  logic [31:0] i_pc_target,
    input  logic [31:0] i_alu_result,
    output logic [31:0] o_next,
    output logic        o_misaligned
);
    assign o_next = (i_pc_src == PC_BRANCH) ? i_pc_target :
                    (i_pc_src == PC_JALR)   ? {i_alu_result[31:1], 1'b0} :
                                              i_pc + 32'd4;
    assign o_misaligned = |o_next[1:0];
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multicycle fetch stage owning PC and IR, with a req/resp instruction-memory port.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic [1:0]  pcSrc,
    input  logic [31:0] pc_target,
    input  logic [31:0] alu_result,
    input  logic        stall,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        misalign,
    output logic [31:0] instret
);
    import fetch_sequencer_pkg::*;
    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_instret;
    logic        r_misalign;
    logic [31:0] w_next;
    logic        w_misaligned;
    pc_next_mux u_pc_next_mux (
        .i_pc        (r_pc),
        .i_pc_src    (pcSrc),
        .i_pc_target (pc_target),
        .i_alu_result(alu_result),
        .o_next      (w_next),
        .o_misaligned(w_misaligned)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_ir       <= NOP_INSTR;
            r_instret  <= '0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                FETCH: if (imem_ready) r_state <= WAIT;
                WAIT: if (imem_rvalid) begin
                    r_ir    <= imem_rdata;
                    r_state <= EXEC;
                end
                EXEC: if (!stall) begin
                    if (w_misaligned) begin
                        r_misalign <= 1'b1;
                        r_state    <= HALT;
                    end else begin
                        r_pc      <= w_next;
                        r_instret <= r_instret + 32'd1;
                        r_state   <= FETCH;
                    end
                end
                default: r_state <= HALT;
            endcase
        end
    end
    // request is masked by rst so nothing is issued while reset is held
    assign imem_req    = (r_state == FETCH) && !rst;
    assign instr_valid = (r_state == EXEC) && !rst;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign pc_plus4    = r_pc + 32'd4;
    assign instr       = r_ir;
    assign op          = r_ir[6:0];
    assign func3       = r_ir[14:12];
    assign func7       = r_ir[31:25];
    assign misalign    = r_misalign;
    assign instret     = r_instret;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vectors with hand-computed expectations for fetch_sequencer.
module tb_fetch_sequencer;
    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [1:0]  pcSrc;
    logic [31:0] pc_target;
    logic [31:0] alu_result;
    logic        stall;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        misalign;
    logic [31:0] instret;
    int n_chk;
    int n_fail;
    int vcount;
    fetch_sequencer dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pcSrc(pcSrc), .pc_target(pc_target), .alu_result(alu_result), .stall(stall),
        .instr(instr), .op(op), .func3(func3), .func7(func7),
        .pc(pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid),
        .misalign(misalign), .instret(instret)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    // entered at a negedge in FETCH; returns at a negedge in EXEC holding data
    task automatic fetch(input logic [31:0] data);
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        @(negedge clk);
        imem_rvalid = 1'b0;
    endtask
    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        imem_ready = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        pcSrc = 2'b00;
        pc_target = '0;
        alu_result = '0;
        stall = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_ir", instr, 32'h13);
        chk("rst_instret", instret, 0);
        chk("rst_misalign", misalign, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("t1_req", imem_req, 1);
        chk("t1_addr", imem_addr, 0);
        fetch(32'h0050_0093);
        chk("t1_valid", instr_valid, 1);
        chk("t1_req_exec", imem_req, 0);
        chk("t1_instr", instr, 32'h0050_0093);
        chk("t1_op", op, 7'h13);
        chk("t1_func3", func3, 0);
        chk("t1_func7", func7, 0);
        chk("t1_pc4", pc_plus4, 32'h4);
        pcSrc = 2'b00;
        @(negedge clk);
        chk("t1_next_addr", imem_addr, 32'h4);
        chk("t1_instret", instret, 1);
        chk("t1_valid_off", instr_valid, 0);
        chk("t1_req_on", imem_req, 1);
        fetch(32'h0380_006f);
        chk("t2_op", op, 7'h6f);
        chk("t2_pc4", pc_plus4, 32'h8);
        pcSrc = 2'b01;
        pc_target = 32'h40;
        @(negedge clk);
        chk("t2_addr", imem_addr, 32'h40);
        chk("t2_instret", instret, 2);
        fetch(32'h0000_8067);
        chk("t3_func3", func3, 0);
        pcSrc = 2'b10;
        alu_result = 32'h81;
        @(negedge clk);
        chk("t3_pc", pc, 32'h80);
        chk("t3_misalign", misalign, 0);
        chk("t3_instret", instret, 3);
        repeat (5) begin
            @(negedge clk);
            chk("t5_addr_hold", imem_addr, 32'h80);
            chk("t5_req_hold", imem_req, 1);
        end
        fetch(32'h0011_2023);
        stall = 1'b1;
        pcSrc = 2'b00;
        vcount = 0;
        repeat (3) begin
            if (instr_valid) vcount++;
            chk("t5_stall_pc", imem_addr, 32'h80);
            @(negedge clk);
        end
        chk("t5_stall_instret", instret, 3);
        stall = 1'b0;
        if (instr_valid) vcount++;
        @(negedge clk);
        chk("t5_valid_cycles", vcount, 4);
        chk("t5_instret", instret, 4);
        chk("t5_addr", imem_addr, 32'h84);
        fetch(32'h0000_0463);
        pcSrc = 2'b01;
        pc_target = 32'h42;
        @(negedge clk);
        chk("t4_misalign", misalign, 1);
        chk("t4_pc", pc, 32'h84);
        chk("t4_instret", instret, 4);
        imem_ready = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hdead_beef;
        repeat (10) begin
            chk("t4_halt_req", imem_req, 0);
            chk("t4_halt_valid", instr_valid, 0);
            @(negedge clk);
        end
        chk("t4_halt_pc", pc, 32'h84);
        chk("t4_halt_ir", instr, 32'h0000_0463);
        imem_ready = 1'b0;
        imem_rvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t4_rec_pc", pc, 0);
        chk("t4_rec_misalign", misalign, 0);
        chk("t4_rec_instret", instret, 0);
        chk("t4_rec_req", imem_req, 1);
        fetch(32'h0000_0013);
        pcSrc = 2'b01;
        pc_target = 32'hffff_fffc;
        @(negedge clk);
        chk("wrap_addr_top", imem_addr, 32'hffff_fffc);
        fetch(32'h0000_0013);
        chk("wrap_pc4", pc_plus4, 0);
        pcSrc = 2'b11;
        @(negedge clk);
        chk("wrap_addr", imem_addr, 0);
        chk("wrap_misalign", misalign, 0);
        chk("wrap_instret", instret, 2);
        fetch(32'h0000_0013);
        pcSrc = 2'b01;
        pc_target = 32'h10;
        @(negedge clk);
        chk("t6_pre_addr", imem_addr, 32'h10);
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        chk("t6_wait_req", imem_req, 0);
        rst = 1'b1;
        #1;
        chk("t6_rst_req", imem_req, 0);
        chk("t6_rst_pc", pc, 0);
        @(negedge clk);
        rst = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hcafe_f00d;
        @(negedge clk);
        imem_rvalid = 1'b0;
        chk("t6_ir_nop", instr, 32'h13);
        chk("t6_valid", instr_valid, 0);
        chk("t6_req", imem_req, 1);
        chk("t6_addr", imem_addr, 0);
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        chk("t6_fresh_wait", imem_req, 0);
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0050_0093;
        @(negedge clk);
        imem_rvalid = 1'b0;
        chk("t6_fresh_ir", instr, 32'h0050_0093);
        chk("t6_fresh_valid", instr_valid, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
